// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: steps a 3-bit address through the eight lines of a
// 3-to-8 decoder at a programmable dwell rate, continuously or as one sweep.
// The decoder enables are held inactive whenever no scan is running.
module decoder_scan_ctrl #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  dir,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  G1,
    output logic                  G2AN,
    output logic                  G3BN,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            addr_q, addr_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic                  dir_q, dir_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  last_addr;

    // Final address of a sweep depends on the latched direction.
    assign last_addr = dir_q ? (addr_q == 3'd0) : (addr_q == 3'd7);

    // Next-state logic: start/stop/pause handling, dwell counting and address stepping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    // Scan parameters are frozen for the whole run.
                    dir_d   = dir;
                    mode_d  = mode;
                    div_d   = div;
                    addr_d  = dir ? 3'd7 : 3'd0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_RUN;
                end else if (cnt_q != div_q) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (mode_q && last_addr) begin
                        // Single sweep finished: address stays on the final line.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = dir_q ? (addr_q - 3'd1) : (addr_q + 3'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset returns everything to its idle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 3'd0;
            cnt_q   <= '0;
            div_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from flops, so they change only at clock edges.
    assign A    = addr_q[2];
    assign B    = addr_q[1];
    assign C    = addr_q[0];
    assign G1   = (state_q == ST_RUN);
    assign G2AN = (state_q != ST_RUN);
    assign G3BN = (state_q != ST_RUN);
    assign busy = (state_q == ST_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Testbench for decoder_scan_ctrl: directed scenarios plus random stimulus,
// all outputs compared each cycle against a position-based reference model.
module tb_decoder_scan_ctrl;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset, start, stop, pause, dir, mode;
    logic [PW-1:0] div;
    logic          A, B, C, G1, G2AN, G3BN, busy, done;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.PRESCALE_W(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .dir(dir), .mode(mode), .div(div),
        .A(A), .B(B), .C(C), .G1(G1), .G2AN(G2AN), .G3BN(G3BN),
        .busy(busy), .done(done)
    );

    // Reference model: a scan is described by the number of unpaused cycles
    // elapsed since start; the address is that count divided by the dwell.
    bit       m_run;
    int       m_pos;
    bit       m_dir, m_mode;
    int       m_div;
    bit [2:0] m_hold;
    bit       m_done;

    function automatic bit [2:0] m_addr();
        int k;
        if (!m_run) return m_hold;
        k = (m_pos / (m_div + 1)) % 8;
        return m_dir ? 3'(7 - k) : 3'(k);
    endfunction

    task automatic model_step();
        if (reset) begin
            m_run = 0; m_hold = 3'd0; m_done = 0; m_pos = 0;
        end else if (!m_run) begin
            m_done = 0;
            if (start && !stop) begin
                m_run = 1; m_pos = 0;
                m_dir = dir; m_mode = mode; m_div = int'(div);
            end
        end else begin
            m_done = 0;
            if (stop) begin
                m_hold = m_addr();
                m_run  = 0;
            end else if (!pause) begin
                m_pos++;
                if (m_mode && m_pos == 8 * (m_div + 1)) begin
                    m_run  = 0;
                    m_done = 1;
                    m_hold = m_dir ? 3'd0 : 3'd7;
                end
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("abc",  {29'd0, A, B, C}, {29'd0, m_addr()});
        check_val("g1",   {31'd0, G1},   {31'd0, m_run});
        check_val("g2an", {31'd0, G2AN}, {31'd0, !m_run});
        check_val("g3bn", {31'd0, G3BN}, {31'd0, !m_run});
        check_val("busy", {31'd0, busy}, {31'd0, m_run});
        check_val("done", {31'd0, done}, {31'd0, m_done});
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; stop = 0; pause = 0; dir = 0; mode = 0; div = '0;
    endtask

    task automatic go_idle();
        idle_inputs();
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic begin_scan(input bit d, input bit m, input int dv);
        start = 1; stop = 0; dir = d; mode = m; div = PW'(dv);
        tick();
        start = 0;
    endtask

    initial begin
        int busy_cnt, done_cnt, a2_cnt, waited;
        logic [2:0] prev_abc, after2;
        bit seen_done;

        idle_inputs();
        reset = 1;
        tick();
        reset = 0;

        // Reset values held for 10 idle cycles.
        for (int i = 0; i < 10; i++) tick();
        check_val("rst_abc",  {29'd0, A, B, C}, 32'd0);
        check_val("rst_g2an", {31'd0, G2AN}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);

        // Up, single sweep, div=2: 24 busy cycles then one done cycle.
        begin_scan(1'b0, 1'b1, 2);
        busy_cnt = 1; done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check_val("sweep_busy_cycles", 32'(busy_cnt), 32'd24);
        check_val("sweep_done_pulses", 32'(done_cnt), 32'd1);
        check_val("sweep_end_abc", {29'd0, A, B, C}, 32'd7);

        // Down, continuous, div=0 for 20 cycles, then stop with no done pulse.
        begin_scan(1'b1, 1'b0, 0);
        for (int i = 0; i < 20; i++) tick();
        stop = 1;
        tick();
        stop = 0;
        check_val("stop_g1", {31'd0, G1}, 32'd0);
        check_val("stop_done", {31'd0, done}, 32'd0);

        // start and stop together while idle: stays idle.
        start = 1; stop = 1; dir = 0; div = 8'd1;
        tick();
        start = 0; stop = 0;
        check_val("start_stop_busy", {31'd0, busy}, 32'd0);

        // Pause 5 cycles while addr=2 with div=3: addr 2 lasts 9 cycles, then 3.
        begin_scan(1'b0, 1'b0, 3);
        a2_cnt = 0; prev_abc = {A, B, C}; after2 = 3'd0;
        for (int i = 1; i <= 24; i++) begin
            pause = (i >= 9 && i <= 13);
            tick();
            if (busy && {A, B, C} == 3'd2) a2_cnt++;
            if (prev_abc == 3'd2 && {A, B, C} != 3'd2) after2 = {A, B, C};
            prev_abc = {A, B, C};
        end
        pause = 0;
        check_val("pause_dwell", 32'(a2_cnt), 32'd9);
        check_val("pause_next", {29'd0, after2}, 32'd3);
        go_idle();

        // Mid-run changes to dir/mode/div/start are ignored; then reset at addr 5.
        begin_scan(1'b0, 1'b0, 1);
        for (int i = 0; i < 12; i++) begin
            dir = 1'($urandom); mode = 1'($urandom); div = PW'($urandom);
            start = 1'($urandom);
            tick();
        end
        start = 0;
        waited = 0;
        while ({A, B, C} != 3'd5 && waited < 40) begin
            tick();
            waited++;
        end
        check_val("mid_reach_addr5", 32'(waited < 40), 32'd1);
        reset = 1;
        tick();
        reset = 0;
        check_val("mid_rst_abc", {29'd0, A, B, C}, 32'd0);
        check_val("mid_rst_done", {31'd0, done}, 32'd0);
        tick();
        check_val("mid_rst_done2", {31'd0, done}, 32'd0);

        // Back-to-back sweeps with start held high through done.
        start = 1; dir = 0; mode = 1; div = '0;
        seen_done = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (seen_done) begin
                check_val("b2b_restart_abc", {29'd0, A, B, C}, 32'd0);
                check_val("b2b_restart_busy", {31'd0, busy}, 32'd1);
            end
            seen_done = done;
            if (done) done_cnt++;
        end
        check_val("b2b_done_seen", 32'(done_cnt > 0), 32'd1);
        go_idle();

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 64) == 0;
            start = ($urandom % 4) == 0;
            stop  = ($urandom % 24) == 0;
            pause = ($urandom % 8) == 0;
            dir   = 1'($urandom);
            mode  = 1'($urandom);
            div   = PW'($urandom % 4);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
